// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_resolve_ctrl_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // One in-flight prediction: the fetched PC and what the predictor said comes next.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pred_pc;
  } pred_entry_t;

  localparam int ENTRY_W = $bits(pred_entry_t);

  // Architecturally correct successor of a resolved instruction.
  function automatic logic [PC_W-1:0] calc_actual_next(
    input logic            is_branch,
    input logic            taken,
    input logic [PC_W-1:0] target,
    input logic [PC_W-1:0] pc
  );
    return (is_branch && taken) ? target : pc + PC_INC;
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order FIFO of prediction entries with wrap-around pointers and a clear input.
// Latency: write visible at head one cycle after push; head is read combinationally.
// Backpressure: push ignored when full unless a pop happens in the same cycle; clr wins over both.
module pred_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  input  logic             clr,
  output logic [WIDTH-1:0] head_dat,
  output logic [4:0]       count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == 5'd0);
  assign do_pop   = pop_vld & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_push  = push_vld & (~full | do_pop) & ~clr;
  assign head_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks predicted fetches in order, checks each against its resolution, drives predictor update and flush.
// Latency: update/flush/redirect appear the cycle after the resolving edge; if_stall is combinational from count.
// Backpressure: if_stall while the queue is full; pushes and resolves are ignored during the flush cycle.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic [PC_W-1:0] if_pred_pc,
  output logic            if_stall,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  output logic            update_pre_en,
  output logic            taken_actual,
  output logic [PC_W-1:0] target_pc_actual,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic [4:0]      count,
  output logic            underflow
);

  state_t           state_q;
  state_t           state_d;
  pred_entry_t      push_entry;
  pred_entry_t      head;
  logic [ENTRY_W-1:0] head_dat;
  logic             in_run;
  logic             push_req;
  logic             pop;
  logic             mispredict;
  logic             underflow_set;
  logic [PC_W-1:0]  actual_next;

  assign in_run        = (state_q == ST_RUN);
  assign push_req      = if_valid & in_run;
  assign pop           = ex_valid & in_run & (count != 5'd0);
  assign underflow_set = ex_valid & in_run & (count == 5'd0);
  assign head          = pred_entry_t'(head_dat);
  assign actual_next   = calc_actual_next(ex_is_branch, ex_taken, ex_target, head.pc);
  assign mispredict    = pop & (actual_next != head.pred_pc);
  assign if_stall      = (count == 5'(DEPTH));

  // Pack the fetch-side fields into one queue entry.
  always_comb begin
    push_entry         = '0;
    push_entry.pc      = if_pc;
    push_entry.pred_pc = if_pred_pc;
  end

  // A mispredict clears the queue, which also drops any push in the same cycle.
  pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_pred_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_req),
    .push_dat (push_entry),
    .pop_vld  (pop),
    .clr      (mispredict),
    .head_dat (head_dat),
    .count    (count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state and flush output: FLUSH lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mispredict) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Predictor update strobe and payload; payload holds across non-branch pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      update_pre_en    <= 1'b0;
      taken_actual     <= 1'b0;
      target_pc_actual <= '0;
    end else begin
      update_pre_en <= pop & ex_is_branch;
      if (pop && ex_is_branch) begin
        taken_actual     <= ex_taken;
        target_pc_actual <= ex_target;
      end
    end
  end

  // Capture the correct next PC at the mispredicting edge for use during FLUSH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          redirect_pc <= '0;
    else if (mispredict) redirect_pc <= actual_next;
  end

  // Sticky error for a resolve arriving with nothing in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             underflow <= 1'b0;
    else if (underflow_set) underflow <= 1'b1;
  end

endmodule
